// File: rtl/tlb_fill_ctrl_pkg.sv
// tlb_fill_ctrl_pkg: shared sizes, field offsets, encodings and entry builder for the TLB fill sequencer
package tlb_fill_ctrl_pkg;
    localparam int ENTRIES = 8;
    localparam int IDX_W = 3;
    localparam int VPN_W = 20;
    localparam int PPN_W = 20;
    localparam int ATTR_W = 7;
    localparam int ENTRY_W = 1 + ATTR_W + VPN_W + PPN_W;
    // Entries are numbered big-endian: bit 0 is the valid flag, VPN sits at [8:27]
    localparam int VPN_LO = 1 + ATTR_W;
    localparam int VPN_HI = VPN_LO + VPN_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_INSERT = 2'b01, OP_PURGE = 2'b10, OP_FLUSH = 2'b11} tlbOp_t;
    typedef enum logic [2:0] {IDLE, WRITE, SCAN, CLEAR, DONE} fillState_t;

    function automatic logic [0:ENTRY_W-1] buildEntry(input logic [ATTR_W-1:0] attr,
                                                      input logic [VPN_W-1:0] vpn,
                                                      input logic [PPN_W-1:0] ppn);
        return {1'b1, attr, vpn, ppn};
    endfunction
endpackage

// File: rtl/tlb_victim_sel.sv
// tlb_victim_sel: picks the lowest free TLB entry, falling back to the round-robin pointer when full
module tlb_victim_sel
    import tlb_fill_ctrl_pkg::*;
(
    input  logic [0:ENTRIES-1] validVec,
    input  logic [IDX_W-1:0]   rrPtr,
    output logic [IDX_W-1:0]   victim,
    output logic               allValid
);
    always_comb begin
        allValid = &validVec;
        victim = rrPtr;
        for (int i = ENTRIES - 1; i >= 0; i--) victim = validVec[i] ? victim : IDX_W'(i);
    end
endmodule

// File: rtl/tlb_fill_ctrl.sv
// tlb_fill_ctrl: owns the TLB RAM write port; sequences insert, purge-by-VPN and flush requests
module tlb_fill_ctrl
    import tlb_fill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               reqValid,
    output logic               reqReady,
    input  logic [1:0]         reqOp,
    input  logic [VPN_W-1:0]   reqVpn,
    input  logic [PPN_W-1:0]   reqPpn,
    input  logic [ATTR_W-1:0]  reqAttr,
    output logic               doneValid,
    output logic               doneHit,
    output logic [IDX_W-1:0]   doneIdx,
    output logic [0:ENTRIES-1] validVec,
    output logic               ramWEnable,
    output logic [IDX_W-1:0]   ramWriteAdr,
    output logic [0:ENTRY_W-1] ramDataIn,
    output logic [IDX_W-1:0]   ramReadAdrA,
    input  logic [0:ENTRY_W-1] ramDataOutA
);
    fillState_t state, nextState;
    tlbOp_t opReg;
    logic [VPN_W-1:0] vpnReg;
    logic [PPN_W-1:0] ppnReg;
    logic [ATTR_W-1:0] attrReg;
    logic [IDX_W-1:0] rrPtr, scanIdx, idxReg, victim, wrIdx;
    logic hitReg, allValid, match;
    logic unusedRamBits;

    tlb_victim_sel victimSel (
        .validVec(validVec),
        .rrPtr(rrPtr),
        .victim(victim),
        .allValid(allValid)
    );

    // The RAM copy of the valid bit is deliberately ignored; validVec is authoritative
    assign unusedRamBits = ^{ramDataOutA[0:VPN_LO-1], ramDataOutA[VPN_HI+1:ENTRY_W-1]};
    assign match = state == SCAN && validVec[scanIdx] && ramDataOutA[VPN_LO:VPN_HI] == vpnReg;
    assign wrIdx = opReg == OP_INSERT ? victim : scanIdx;

    assign reqReady = state == IDLE && !rst;
    assign ramWEnable = state == WRITE || state == CLEAR;
    assign ramWriteAdr = state == WRITE ? wrIdx : state == CLEAR ? scanIdx : '0;
    assign ramDataIn = state == WRITE && opReg == OP_INSERT ? buildEntry(attrReg, vpnReg, ppnReg) : '0;
    assign ramReadAdrA = state == SCAN ? scanIdx : '0;
    assign doneValid = state == DONE;
    assign doneHit = doneValid & hitReg;
    assign doneIdx = doneValid ? idxReg : '0;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = !reqValid ? IDLE : reqOp == OP_INSERT ? WRITE :
                                 reqOp == OP_PURGE ? SCAN : reqOp == OP_FLUSH ? CLEAR : IDLE;
            SCAN:    nextState = match ? WRITE : scanIdx == LAST_IDX ? DONE : SCAN;
            WRITE:   nextState = DONE;
            CLEAR:   nextState = scanIdx == LAST_IDX ? DONE : CLEAR;
            default: nextState = IDLE;
        endcase
    end

    // scanIdx always returns to 0 before IDLE, so SCAN and CLEAR start from entry 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opReg <= OP_NOP;
            vpnReg <= '0;
            ppnReg <= '0;
            attrReg <= '0;
            validVec <= '0;
            rrPtr <= '0;
            scanIdx <= '0;
            idxReg <= '0;
            hitReg <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: if (reqValid) begin
                    opReg <= tlbOp_t'(reqOp);
                    vpnReg <= reqVpn;
                    ppnReg <= reqPpn;
                    attrReg <= reqAttr;
                end
                SCAN: if (!match) begin
                    scanIdx <= scanIdx + IDX_W'(1);
                    hitReg <= 1'b0;
                    idxReg <= '0;
                end
                WRITE: begin
                    validVec[wrIdx] <= opReg == OP_INSERT;
                    idxReg <= wrIdx;
                    hitReg <= 1'b1;
                    scanIdx <= '0;
                    if (opReg == OP_INSERT && allValid) rrPtr <= rrPtr + IDX_W'(1);
                end
                CLEAR: begin
                    scanIdx <= scanIdx + IDX_W'(1);
                    if (scanIdx == LAST_IDX) begin
                        validVec <= '0;
                        rrPtr <= '0;
                        idxReg <= '0;
                        hitReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// tb_tlb_fill_ctrl: directed and random requests against a set/queue reference model of the TLB
module tb_tlb_fill_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic reqValid = 1'b0, reqReady;
    logic [1:0] reqOp = '0;
    logic [19:0] reqVpn = '0, reqPpn = '0;
    logic [6:0] reqAttr = '0;
    logic doneValid, doneHit, ramWEnable;
    logic [2:0] doneIdx, ramWriteAdr, ramReadAdrA;
    logic [0:7] validVec;
    logic [0:47] ramDataIn, ramDataOutA;
    logic [0:47] ram [8];

    int checks = 0, failures = 0;
    bit mv [8];
    logic [19:0] mvpn [8];
    int rr = 0;
    logic [2:0] lastWrIdx;
    logic [0:47] lastWrData;

    always #5 clk = ~clk;
    always @(posedge clk) if (ramWEnable) ram[ramWriteAdr] <= ramDataIn;
    assign ramDataOutA = ram[ramReadAdrA];

    tlb_fill_ctrl dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqVpn(reqVpn), .reqPpn(reqPpn), .reqAttr(reqAttr), .doneValid(doneValid),
        .doneHit(doneHit), .doneIdx(doneIdx), .validVec(validVec), .ramWEnable(ramWEnable),
        .ramWriteAdr(ramWriteAdr), .ramDataIn(ramDataIn), .ramReadAdrA(ramReadAdrA),
        .ramDataOutA(ramDataOutA)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expVec();
        logic [0:7] v;
        for (int i = 0; i < 8; i++) v[i] = mv[i];
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        rr = 0;
    endtask

    task automatic runOp(input logic [1:0] op, input logic [19:0] vpn, input logic [19:0] ppn, input logic [6:0] attr);
        int ewc[$], awc[$];
        logic [2:0] ewi[$], awi[$];
        logic [0:47] ewd[$], awd[$];
        int k, lat, scanN, limit;
        bit expHit, got;
        logic [2:0] expIdx;
        k = -1; lat = 0; scanN = 0; expHit = 1'b0; expIdx = '0; got = 1'b0;
        if (op == 2'b01) begin
            for (int i = 0; i < 8; i++) if (!mv[i] && k < 0) k = i;
            if (k < 0) begin k = rr; rr = (rr + 1) % 8; end
            ewc.push_back(1); ewi.push_back(3'(k)); ewd.push_back({1'b1, attr, vpn, ppn});
            lat = 2; expHit = 1'b1; expIdx = 3'(k); mv[k] = 1'b1; mvpn[k] = vpn;
        end else if (op == 2'b10) begin
            for (int i = 0; i < 8; i++) if (mv[i] && mvpn[i] == vpn && k < 0) k = i;
            if (k >= 0) begin
                scanN = k + 1; lat = k + 3; expHit = 1'b1; expIdx = 3'(k); mv[k] = 1'b0;
                ewc.push_back(k + 2); ewi.push_back(3'(k)); ewd.push_back('0);
            end else begin
                scanN = 8; lat = 9;
            end
        end else if (op == 2'b11) begin
            for (int i = 0; i < 8; i++) begin
                ewc.push_back(i + 1); ewi.push_back(3'(i)); ewd.push_back('0);
            end
            lat = 9; expHit = 1'b1; modelReset();
        end
        @(negedge clk);
        chk("ready_idle", reqReady, 1);
        reqValid = 1'b1; reqOp = op; reqVpn = vpn; reqPpn = ppn; reqAttr = attr;
        @(posedge clk);
        #1;
        reqValid = 1'b0; reqOp = 2'($urandom); reqVpn = 20'($urandom); reqPpn = 20'($urandom); reqAttr = 7'($urandom);
        limit = lat == 0 ? 3 : 12;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            chk("read_adr", ramReadAdrA, c <= scanN ? c - 1 : 0);
            if (ramWEnable) begin awc.push_back(c); awi.push_back(ramWriteAdr); awd.push_back(ramDataIn); end
            if (doneValid) begin
                got = 1'b1;
                chk("done_latency", c, lat);
                chk("done_hit", doneHit, expHit);
                chk("done_idx", doneIdx, expIdx);
                chk("valid_vec", validVec, expVec());
                break;
            end
        end
        chk("done_seen", got, lat != 0);
        chk("write_count", awc.size(), ewc.size());
        for (int i = 0; i < ewc.size() && i < awc.size(); i++) begin
            chk("write_cycle", awc[i], ewc[i]);
            chk("write_idx", awi[i], ewi[i]);
            chk("write_data", awd[i], ewd[i]);
        end
        if (awc.size() > 0) begin lastWrIdx = awi[$]; lastWrData = awd[$]; end
        if (lat != 0) begin
            @(negedge clk);
            chk("done_single_pulse", {doneValid, doneHit, doneIdx}, 0);
            chk("ready_after_done", reqReady, 1);
        end
    endtask

    initial begin
        modelReset();
        #1;
        chk("reset_outputs", {reqReady, doneValid, doneHit, doneIdx, validVec, ramWEnable, ramWriteAdr, ramDataIn, ramReadAdrA}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_out_of_reset", reqReady, 1);
        chk("reset_valid_vec", validVec, 0);

        runOp(2'b01, 20'h00012, 20'h00034, 7'h05);
        chk("t1_data", lastWrData, 48'h850001200034);
        chk("t1_idx", lastWrIdx, 0);
        chk("t1_vec", validVec, 8'h80);

        for (int i = 1; i < 8; i++) runOp(2'b01, 20'h00100 + 20'(i), 20'($urandom), 7'($urandom));
        runOp(2'b01, 20'h00200, 20'h00aaa, 7'h11);
        chk("t2_rr_first", lastWrIdx, 0);
        runOp(2'b01, 20'h00201, 20'h00bbb, 7'h22);
        chk("t2_rr_second", lastWrIdx, 1);
        chk("t2_vec", validVec, 8'hFF);

        runOp(2'b10, 20'h00105, '0, '0);
        chk("t3_idx", lastWrIdx, 5);
        chk("t3_vec", validVec, 8'hFB);

        runOp(2'b10, 20'hABCDE, '0, '0);
        runOp(2'b01, 20'h00300, 20'h00ccc, 7'h33);
        chk("t4_lowest_free", lastWrIdx, 5);

        runOp(2'b11, '0, '0, '0);
        chk("t5_vec", validVec, 0);
        for (int i = 0; i < 9; i++) runOp(2'b01, 20'h00400 + 20'(i), 20'($urandom), 7'($urandom));
        chk("t5_rr_restart", lastWrIdx, 0);

        runOp(2'b00, 20'h12345, '0, '0);

        for (int n = 0; n < 80; n++) begin
            int r, pick;
            logic [19:0] v;
            r = $urandom_range(0, 99);
            v = 20'($urandom);
            if (r < 45) runOp(2'b01, v, 20'($urandom), 7'($urandom));
            else if (r < 85) begin
                pick = $urandom_range(0, 7);
                if (mv[pick] && $urandom_range(0, 3) != 0) v = mvpn[pick];
                runOp(2'b10, v, 20'($urandom), 7'($urandom));
            end else if (r < 92) runOp(2'b11, v, '0, '0);
            else runOp(2'b00, v, '0, '0);
        end

        for (int i = 0; i < 5; i++) runOp(2'b01, 20'h00500 + 20'(i), 20'($urandom), 7'($urandom));
        @(negedge clk);
        reqValid = 1'b1; reqOp = 2'b11;
        @(posedge clk);
        #1 reqValid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_outputs_in_reset", {reqReady, doneValid, doneHit, doneIdx, validVec, ramWEnable, ramWriteAdr, ramDataIn, ramReadAdrA}, 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_ready_after_release", reqReady, 1);
        chk("t6_vec_after_release", validVec, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("t6_quiet", {doneValid, ramWEnable}, 0);
        end
        runOp(2'b01, 20'h00777, 20'h00888, 7'h44);
        chk("t6_insert_after_reset", lastWrIdx, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
